// File: rtl/batrider_video_timing.sv
// Raster timing generator for a 432x262 (320x240 visible) display.
// Outputs are registered from next-state counters, so syncs and blanks line up with HCNT/VCNT.
module batrider_video_timing #(
    parameter int unsigned H_TOTAL  = 432,
    parameter int unsigned H_VIS    = 320,
    parameter int unsigned HS_START = 336,
    parameter int unsigned HS_END   = 368,
    parameter int unsigned V_TOTAL  = 262,
    parameter int unsigned V_VIS    = 240,
    parameter int unsigned VS_START = 245,
    parameter int unsigned VS_END   = 248
) (
    input  logic       CLK96,
    input  logic       RESET96,
    input  logic       CEN675,
    output logic [8:0] HCNT,
    output logic [8:0] VCNT,
    output logic       HS,
    output logic       VS,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       VINT,
    output logic       FRAME
);

    localparam int unsigned CW = 9;

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          vint_q, vint_d;
    logic          frame_q, frame_d;
    logic          h_wrap, v_wrap;

    // Next-state counters and the decodes derived from them.
    always_comb begin
        h_wrap   = (32'(hcnt_q) == H_TOTAL - 1);
        v_wrap   = (32'(vcnt_q) == V_TOTAL - 1);
        hcnt_d   = h_wrap ? '0 : hcnt_q + CW'(1);
        vcnt_d   = vcnt_q;
        frame_d  = frame_q;
        if (h_wrap) begin
            vcnt_d = v_wrap ? '0 : vcnt_q + CW'(1);
            if (v_wrap) begin
                frame_d = ~frame_q;
            end
        end
        hblank_d = (32'(hcnt_d) >= H_VIS);
        vblank_d = (32'(vcnt_d) >= V_VIS);
        hs_d     = !((32'(hcnt_d) >= HS_START) && (32'(hcnt_d) < HS_END));
        vs_d     = !((32'(vcnt_d) >= VS_START) && (32'(vcnt_d) < VS_END));
        vint_d   = h_wrap && (32'(vcnt_d) == V_VIS);
    end

    // VINT is a strobe: cleared on every non-enabled cycle so it never stretches.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            vint_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            vint_q <= 1'b0;
            if (CEN675) begin
                hcnt_q   <= hcnt_d;
                vcnt_q   <= vcnt_d;
                hs_q     <= hs_d;
                vs_q     <= vs_d;
                hblank_q <= hblank_d;
                vblank_q <= vblank_d;
                vint_q   <= vint_d;
                frame_q  <= frame_d;
            end
        end
    end

    assign HCNT   = hcnt_q;
    assign VCNT   = vcnt_q;
    assign HS     = hs_q;
    assign VS     = vs_q;
    assign HBLANK = hblank_q;
    assign VBLANK = vblank_q;
    assign VINT   = vint_q;
    assign FRAME  = frame_q;

endmodule

// File: doc/batrider_video_timing.md
BATRIDER_VIDEO_TIMING -- requirements
Module: batrider_video_timing

Interface
REQ-001 SHALL provide parameter H_TOTAL, default 432, pixels per line including blanking.
REQ-002 SHALL provide parameter H_VIS, default 320, visible pixels per line.
REQ-003 SHALL provide parameter HS_START, default 336, first HCNT value with HS active.
REQ-004 SHALL provide parameter HS_END, default 368, first HCNT value with HS inactive again.
REQ-005 SHALL provide parameter V_TOTAL, default 262, lines per frame including blanking.
REQ-006 SHALL provide parameter V_VIS, default 240, visible lines per frame.
REQ-007 SHALL provide parameter VS_START, default 245, first VCNT value with VS active.
REQ-008 SHALL provide parameter VS_END, default 248, first VCNT value with VS inactive again.
REQ-009 SHALL have port CLK96  input  1  96 MHz system clock; sole clock, all logic on rising edge.
REQ-010 SHALL have port RESET96  input  1  synchronous, active-high reset.
REQ-011 SHALL have port CEN675  input  1  6.75 MHz pixel clock enable, one CLK96 cycle wide.
REQ-012 SHALL have port HCNT  output  9  horizontal pixel counter.
REQ-013 SHALL have port VCNT  output  9  vertical line counter.
REQ-014 SHALL have port HS  output  1  horizontal sync, active low.
REQ-015 SHALL have port VS  output  1  vertical sync, active low.
REQ-016 SHALL have port HBLANK  output  1  high during horizontal blanking.
REQ-017 SHALL have port VBLANK  output  1  high during vertical blanking.
REQ-018 SHALL have port VINT  output  1  vertical-blank interrupt strobe, one CLK96 cycle.
REQ-019 SHALL have port FRAME  output  1  toggles once per completed frame.

Function
REQ-020 SHALL hold all state and outputs unchanged on any CLK96 edge where CEN675=0 and RESET96=0.
REQ-021 SHALL, on a CEN675=1 edge, increment HCNT; HCNT=H_TOTAL-1 wraps to 0.
REQ-022 SHALL increment VCNT on the same edge HCNT wraps; VCNT=V_TOTAL-1 with HCNT wrap sets VCNT to 0.
REQ-023 SHALL toggle FRAME on the edge where both HCNT and VCNT wrap to 0.
REQ-024 SHALL register all outputs and compute them from next-state counter values, so HS/VS/HBLANK/VBLANK align with the HCNT/VCNT shown on the same cycle (zero relative latency).
REQ-025 SHALL drive HBLANK=1 exactly when HCNT >= H_VIS.
REQ-026 SHALL drive VBLANK=1 exactly when VCNT >= V_VIS.
REQ-027 SHALL drive HS=0 exactly when HS_START <= HCNT < HS_END; else 1.
REQ-028 SHALL drive VS=0 exactly when VS_START <= VCNT < VS_END; else 1 (line-granular, no half-line offset).
REQ-029 SHALL pulse VINT=1 for exactly one CLK96 cycle, the cycle after the CEN675 edge that sets VCNT=V_VIS, HCNT=0; VINT=0 at all other times, including while CEN675 held high continuously.
REQ-030 SHALL tolerate CEN675 held high every cycle (advance once per CLK96) without loss of wrap behaviour.
REQ-031 SHALL compare counters at 9-bit unsigned width; parameters SHALL satisfy H_VIS<HS_START<HS_END<=H_TOTAL<=512 and V_VIS<VS_START<VS_END<=V_TOTAL<=512; out-of-range parameters are unsupported.

Reset
REQ-032 SHALL, on a CLK96 edge with RESET96=1, set HCNT=0, VCNT=0, HS=1, VS=1, HBLANK=0, VBLANK=0, VINT=0, FRAME=0, regardless of CEN675.
REQ-033 SHALL give RESET96 priority over CEN675 on the same edge; counting resumes on the first CEN675=1 edge after RESET96 falls, producing HCNT=1.
REQ-034 SHALL abort any in-progress line/frame on reset without emitting VINT or FRAME toggle.

Verification
REQ-035 Reset, then 432 CEN675 pulses (every 14th cycle) -> HCNT 431->0, VCNT 0->1, FRAME=0.
REQ-036 Sweep one line -> HBLANK rises with HCNT=320, falls with HCNT=0; HS=0 for HCNT 336..367 only (32 pixels).
REQ-037 Run 113184 CEN675 pulses from reset -> VCNT returns to 0, FRAME=1, VINT seen exactly once at VCNT=240 HCNT=0, VS=0 for lines 245..247, VBLANK=1 for lines 240..261.
REQ-038 CEN675 held 0 for 50 cycles mid-line at HCNT=200 -> all outputs unchanged throughout.
REQ-039 RESET96=1 with CEN675=1 at HCNT=100, VCNT=241 -> next cycle HCNT=0, VCNT=0, HS=VS=1, blanks=0, VINT=0.
REQ-040 CEN675 held 1 continuously for one frame -> VINT single-cycle, counters wrap at 431/261.
